// File: rtl/l_shl_responder_if.sv
// Ready/done handshake bundle for the L_shl basic-op responder.
//   ready    : client request, held with operands stable until done
//   var1     : 32-bit two's complement operand
//   numShift : 16-bit two's complement shift count (negative = shift right)
//   out      : 32-bit result, valid while done=1 and held afterwards
//   done     : one-cycle completion pulse
//   overflow : current or last operation saturated
interface l_shl_responder_if;
  logic        ready;
  logic [31:0] var1;
  logic [15:0] numShift;
  logic [31:0] out;
  logic        done;
  logic        overflow;

  modport master (
    output ready, var1, numShift,
    input  out, done, overflow
  );

  modport slave (
    input  ready, var1, numShift,
    output out, done, overflow
  );
endinterface

// File: rtl/l_shl_responder.sv
// Sequential G.729 L_shl(L_var1, var2) responder on the shared ready/done
// handshake. Left shifts run one bit per cycle with per-step saturation;
// right shifts (numShift <= 0) complete in one cycle.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : l_shl_responder_if slave (ready/var1/numShift in, out/done/overflow out)
module l_shl_responder #(
  parameter int unsigned MAX_LSHIFT = 32
) (
  input  logic              clk,
  input  logic              reset,
  l_shl_responder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_LSHIFT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [31:0] SAT_HI = 32'sh3FFF_FFFF;
  localparam logic signed [31:0] SAT_LO = 32'shC000_0000;

  logic [1:0]         state, state_n;
  logic signed [31:0] acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [31:0]        out_q, out_n;
  logic               ovf_q, ovf_n;
  logic               done_q, done_n;

  logic signed [16:0] rs_amt;
  logic [31:0]        rs_result;
  logic [CNT_W-1:0]   cnt_load;

  // Right-shift result; the 17-bit negation keeps numShift=-32768 positive.
  always_comb begin
    rs_amt = -$signed({bus.numShift[15], bus.numShift});
    if (rs_amt >= 17'sd31) begin
      rs_result = bus.var1[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
    end else begin
      rs_result = 32'($signed(bus.var1) >>> rs_amt[4:0]);
    end
  end

  // Left-shift iteration count, clamped: beyond MAX_LSHIFT the result is fixed.
  always_comb begin
    if (bus.numShift > 16'(MAX_LSHIFT)) begin
      cnt_load = CNT_W'(MAX_LSHIFT);
    end else begin
      cnt_load = CNT_W'(bus.numShift);
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    out_n   = out_q;
    ovf_n   = ovf_q;
    case (state)
      S_IDLE: begin
        if (bus.ready) begin
          ovf_n = 1'b0;
          if ($signed(bus.numShift) <= 16'sd0) begin
            out_n   = rs_result;
            state_n = S_DONE;
          end else begin
            acc_n   = $signed(bus.var1);
            cnt_n   = cnt_load;
            state_n = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (!bus.ready) begin
          // Client withdrew: abort silently, outputs keep prior values.
          state_n = S_IDLE;
        end else if (acc > SAT_HI) begin
          out_n   = 32'h7FFF_FFFF;
          ovf_n   = 1'b1;
          state_n = S_DONE;
        end else if (acc < SAT_LO) begin
          out_n   = 32'h8000_0000;
          ovf_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          acc_n = acc <<< 1;
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_n   = 32'(acc <<< 1);
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    done_n = (state_n == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      out_q  <= out_n;
      ovf_q  <= ovf_n;
      done_q <= done_n;
    end
  end

  assign bus.out      = out_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_l_shl_responder.sv
// Self-checking bench for l_shl_responder: directed cases from the G.729
// L_shl rules followed by randomized operations against a reference model.
module tb_l_shl_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  l_shl_responder_if bus();

  l_shl_responder #(.MAX_LSHIFT(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L_shl reference: result, overflow flag and done latency (cycles after capture).
  function automatic void ref_model(input logic [31:0] v, input logic [15:0] ns,
                                    output logic [31:0] r, output logic o,
                                    output int lat);
    int     n;
    int     s;
    int     steps;
    longint a;
    bit     stop;
    n = int'($signed(ns));
    o = 1'b0;
    r = 32'h0;
    if (n <= 0) begin
      s   = -n;
      lat = 1;
      if (s >= 31) r = v[31] ? 32'hFFFF_FFFF : 32'h0;
      else         r = 32'($signed(v) >>> s);
    end else begin
      steps = (n > 32) ? 32 : n;
      lat   = steps + 1;
      a     = longint'($signed(v));
      stop  = 1'b0;
      for (int k = 0; k < steps; k++) begin
        if (!stop) begin
          if (a > 64'sd1073741823) begin
            r = 32'h7FFF_FFFF; o = 1'b1; lat = k + 2; stop = 1'b1;
          end else if (a < -64'sd1073741824) begin
            r = 32'h8000_0000; o = 1'b1; lat = k + 2; stop = 1'b1;
          end else begin
            a = a * 2;
          end
        end
      end
      if (!o) r = 32'(a);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] v, input logic [15:0] ns);
    bus.ready    = 1'b1;
    bus.var1     = v;
    bus.numShift = ns;
  endtask

  // Next posedge ends capture cycle T; checks latency, out and overflow at done.
  task automatic wait_check(input string tag, input logic [31:0] v, input logic [15:0] ns);
    logic [31:0] er;
    logic        eo;
    int          elat;
    int          c;
    ref_model(v, ns, er, eo, elat);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      if (c == 0) begin
        @(posedge clk); #1;
        if (bus.done === 1'b1) c = i;
      end
    end
    check({tag, "_latency"}, 32'(c), 32'(elat));
    check({tag, "_out"}, bus.out, er);
    check({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, eo});
  endtask

  // Full operation with ready released in the done cycle.
  task automatic run_op(input string tag, input logic [31:0] v, input logic [15:0] ns);
    @(negedge clk);
    drive(v, ns);
    wait_check(tag, v, ns);
    bus.ready = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, bus.done}, 32'h0);
  endtask

  initial begin
    logic [31:0] prev_out;
    logic [31:0] rv;
    logic [15:0] rn;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.ready    = 1'b0;
    bus.var1     = '0;
    bus.numShift = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", bus.out, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_ovf", {31'b0, bus.overflow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("lsh4",     32'h0000_1234, 16'd4);
    run_op("sat_pos",  32'h4000_0000, 16'd1);
    run_op("sat_neg",  32'hA000_0000, 16'd3);
    run_op("rsh4",     32'h8000_0000, 16'hFFFC);
    run_op("zero_sh",  32'h1234_5678, 16'd0);
    run_op("rsh40",    32'hFFFF_FFFF, 16'hFFD8);
    run_op("rsh32",    32'h7FFF_FFFF, 16'hFFE0);
    run_op("rsh_min_n", 32'h8765_4321, 16'h8000);
    run_op("rsh_min_p", 32'h1234_5678, 16'h8000);
    run_op("zero_big", 32'h0000_0000, 16'd100);
    run_op("one_40",   32'h0000_0001, 16'd40);
    run_op("neg_lsh",  32'hFFFF_FFF0, 16'd20);
    run_op("lsh4_b",   32'h0000_1234, 16'd4);

    // Abort: ready dropped at T+3 during SHIFT.
    prev_out = 32'h0001_2340;
    @(negedge clk);
    drive(32'h0000_0055, 16'd10);
    repeat (3) @(posedge clk);
    #1;
    bus.ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'b0, bus.done}, 32'h0);
    end
    check("abort_out", bus.out, prev_out);
    check("abort_ovf", {31'b0, bus.overflow}, 32'h0);
    run_op("after_abort", 32'h0000_0003, 16'd2);

    // Reset asserted mid-SHIFT.
    @(negedge clk);
    drive(32'h0000_0001, 16'd20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    bus.ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_out", bus.out, 32'h0);
    check("midrst_done", {31'b0, bus.done}, 32'h0);
    check("midrst_ovf", {31'b0, bus.overflow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_idle", {31'b0, bus.done}, 32'h0);
    end
    run_op("after_rst", 32'h4000_0000, 16'd2);

    // Back-to-back: ready held through done, new operands presented for the IDLE cycle.
    @(negedge clk);
    drive(32'hC000_0000, 16'hFFFE);
    wait_check("b2b_first", 32'hC000_0000, 16'hFFFE);
    drive(32'h0000_0007, 16'd3);
    @(posedge clk); #1;
    check("b2b_gap", {31'b0, bus.done}, 32'h0);
    wait_check("b2b_second", 32'h0000_0007, 16'd3);
    bus.ready = 1'b0;
    @(posedge clk); #1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom;
        1: rv = 32'($urandom_range(0, 255)) << $urandom_range(0, 28);
        2: rv = -(32'($urandom_range(1, 4095)));
        default: rv = 32'($urandom_range(0, 3)) - 32'd1;
      endcase
      case ($urandom_range(0, 3))
        0: rn = 16'($urandom_range(1, 40));
        1: rn = -(16'($urandom_range(0, 40)));
        2: rn = 16'($urandom);
        default: rn = 16'($urandom_range(0, 8));
      endcase
      run_op("rand", rv, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
